// File: rtl/shared_ram_pkg.sv
// Shared constants and port-select encoding for the two-port shared byte RAM.
package shared_ram_pkg;

   localparam int unsigned DEF_DATA_W = 16;
   localparam int unsigned DEF_ADDR_W = 8;

   typedef enum logic {
      PORT1 = 1'b0,
      PORT2 = 1'b1
   } port_sel_t;

endpackage

// File: rtl/shared_ram_arb.sv
// Round-robin arbiter for the two RAM ports; priority flips only on contended cycles.
module shared_ram_arb
   import shared_ram_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      req1,
   input  logic      req2,
   output port_sel_t grant,
   output logic      busy1,
   output logic      busy2
);

   port_sel_t last_winner;

   // Lone requester always wins; on contention the previous loser wins.
   always_comb begin
      grant = PORT1;
      if (req1 && req2) begin
         grant = (last_winner == PORT1) ? PORT2 : PORT1;
      end else if (req2) begin
         grant = PORT2;
      end
   end

   assign busy1 = req1 && (grant != PORT1);
   assign busy2 = req2 && (grant != PORT2);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_winner <= PORT2;
      end else if (req1 && req2) begin
         last_winner <= grant;
      end
   end

endmodule

// File: rtl/shared_ram_2p.sv
// Two-port shared byte-organised RAM: one access per clock, latency 1, wrapping byte addresses.
module shared_ram_2p
   import shared_ram_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned ADDR_W    = DEF_ADDR_W,
   parameter bit          INIT_ZERO = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                p1_req,
   input  logic                p1_we,
   input  logic [ADDR_W-1:0]   p1_addr,
   input  logic [DATA_W/8-1:0] p1_be,
   input  logic [DATA_W-1:0]   p1_wdata,
   output logic [DATA_W-1:0]   p1_rdata,
   output logic                p1_ack,
   output logic                p1_busy,
   input  logic                p2_req,
   input  logic                p2_we,
   input  logic [ADDR_W-1:0]   p2_addr,
   input  logic [DATA_W/8-1:0] p2_be,
   input  logic [DATA_W-1:0]   p2_wdata,
   output logic [DATA_W-1:0]   p2_rdata,
   output logic                p2_ack,
   output logic                p2_busy
);

   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned DEPTH = 1 << ADDR_W;

   // Configuration-time contents only; reset never touches the array.
   logic [7:0] mem [DEPTH] = '{default: (INIT_ZERO ? 8'h00 : 8'hxx)};

   port_sel_t           grant;
   logic                any_req;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [NB-1:0]       sel_be;
   logic [DATA_W-1:0]   sel_wdata;
   logic [DATA_W-1:0]   rd_word;

   shared_ram_arb u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req1  (p1_req),
      .req2  (p2_req),
      .grant (grant),
      .busy1 (p1_busy),
      .busy2 (p2_busy)
   );

   assign any_req = p1_req || p2_req;

   // Steer the granted port onto the single array access path.
   always_comb begin
      sel_we    = p1_we;
      sel_addr  = p1_addr;
      sel_be    = p1_be;
      sel_wdata = p1_wdata;
      if (grant == PORT2) begin
         sel_we    = p2_we;
         sel_addr  = p2_addr;
         sel_be    = p2_be;
         sel_wdata = p2_wdata;
      end
   end

   always_comb begin
      rd_word = '0;
      for (int k = 0; k < NB; k++) begin
         rd_word[8*k +: 8] = mem[sel_addr + ADDR_W'(k)];
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && any_req && sel_we) begin
         for (int k = 0; k < NB; k++) begin
            if (sel_be[k]) begin
               mem[sel_addr + ADDR_W'(k)] <= sel_wdata[8*k +: 8];
            end
         end
      end
   end

   // rdata only moves on a read completion of its own port.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         p1_ack   <= 1'b0;
         p2_ack   <= 1'b0;
         p1_rdata <= '0;
         p2_rdata <= '0;
      end else begin
         p1_ack <= any_req && (grant == PORT1);
         p2_ack <= any_req && (grant == PORT2);
         if (any_req && !sel_we) begin
            if (grant == PORT1) begin
               p1_rdata <= rd_word;
            end else begin
               p2_rdata <= rd_word;
            end
         end
      end
   end

endmodule

// File: tb/tb_shared_ram_2p.sv
// Bench for shared_ram_2p: directed scenarios then randomized two-port traffic against a byte-array model.
module tb_shared_ram_2p;

   typedef struct packed {
      logic        we;
      logic [7:0]  addr;
      logic [1:0]  be;
      logic [15:0] wdata;
   } op_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        p1_req, p1_we, p1_ack, p1_busy;
   logic [7:0]  p1_addr;
   logic [1:0]  p1_be;
   logic [15:0] p1_wdata, p1_rdata;
   logic        p2_req, p2_we, p2_ack, p2_busy;
   logic [7:0]  p2_addr;
   logic [1:0]  p2_be;
   logic [15:0] p2_wdata, p2_rdata;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0]  ref_mem [256];
   logic [15:0] exp_rd  [2];
   int          prio;          // 0: port 1 wins next contention, 1: port 2
   op_t         op      [2];
   bit          pend    [2];
   op_t         idle_op;

   always #5 clk = ~clk;

   shared_ram_2p #(
      .DATA_W    (16),
      .ADDR_W    (8),
      .INIT_ZERO (1'b1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .p1_req   (p1_req),
      .p1_we    (p1_we),
      .p1_addr  (p1_addr),
      .p1_be    (p1_be),
      .p1_wdata (p1_wdata),
      .p1_rdata (p1_rdata),
      .p1_ack   (p1_ack),
      .p1_busy  (p1_busy),
      .p2_req   (p2_req),
      .p2_we    (p2_we),
      .p2_addr  (p2_addr),
      .p2_be    (p2_be),
      .p2_wdata (p2_wdata),
      .p2_rdata (p2_rdata),
      .p2_ack   (p2_ack),
      .p2_busy  (p2_busy)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ref_read(input logic [7:0] a);
      logic [7:0] a1;
      a1 = a + 8'd1;
      return {ref_mem[a1], ref_mem[a]};
   endfunction

   task automatic ref_apply(input int p, input op_t o);
      logic [7:0] a;
      if (o.we) begin
         for (int k = 0; k < 2; k++) begin
            a = o.addr + 8'(k);
            if (o.be[k]) ref_mem[a] = o.wdata[8*k +: 8];
         end
      end else begin
         exp_rd[p] = ref_read(o.addr);
      end
   endtask

   task automatic set_port(input int p, input logic req, input op_t o);
      if (p == 0) begin
         p1_req = req; p1_we = o.we; p1_addr = o.addr; p1_be = o.be; p1_wdata = o.wdata;
      end else begin
         p2_req = req; p2_we = o.we; p2_addr = o.addr; p2_be = o.be; p2_wdata = o.wdata;
      end
   endtask

   function automatic op_t rand_op();
      op_t o;
      o.we    = 1'($urandom_range(0, 1));
      o.addr  = 8'(32'hF8 + $urandom_range(0, 15));
      o.be    = 2'($urandom_range(0, 3));
      o.wdata = 16'($urandom);
      return o;
   endfunction

   // Uncontended access on one port; called just after a rising edge.
   task automatic single(input int p, input logic we, input logic [7:0] a,
                         input logic [1:0] be, input logic [15:0] d);
      op_t o;
      o = '{we: we, addr: a, be: be, wdata: d};
      set_port(p, 1'b1, o);
      set_port(1 - p, 1'b0, idle_op);
      #1;
      chk1($sformatf("p%0d_busy_solo", p + 1), (p == 0) ? p1_busy : p2_busy, 1'b0);
      @(posedge clk); #1;
      ref_apply(p, o);
      set_port(p, 1'b0, o);
      chk1($sformatf("p%0d_ack", p + 1), (p == 0) ? p1_ack : p2_ack, 1'b1);
      chk1($sformatf("p%0d_other_ack", p + 1), (p == 0) ? p2_ack : p1_ack, 1'b0);
      chk16("p1_rdata", p1_rdata, exp_rd[0]);
      chk16("p2_rdata", p2_rdata, exp_rd[1]);
   endtask

   // One clock of two-port traffic; force keeps both ports requesting.
   task automatic traffic_cycle(input bit force_both, input int c);
      int win;
      for (int p = 0; p < 2; p++) begin
         if (!pend[p] && (force_both || $urandom_range(0, 99) < 60)) begin
            op[p]   = rand_op();
            pend[p] = 1'b1;
         end
         set_port(p, pend[p], op[p]);
      end
      if (pend[0] && pend[1]) begin
         win  = prio;
         prio = 1 - prio;
      end else if (pend[0]) begin
         win = 0;
      end else if (pend[1]) begin
         win = 1;
      end else begin
         win = -1;
      end
      #1;
      chk1("p1_busy", p1_busy, pend[0] && (win != 0));
      chk1("p2_busy", p2_busy, pend[1] && (win != 1));
      @(posedge clk); #1;
      if (win >= 0) begin
         ref_apply(win, op[win]);
         pend[win] = 1'b0;
      end
      chk1("p1_ack", p1_ack, win == 0);
      chk1("p2_ack", p2_ack, win == 1);
      chk1("no_double_ack", p1_ack && p2_ack, 1'b0);
      chk16("p1_rdata", p1_rdata, exp_rd[0]);
      chk16("p2_rdata", p2_rdata, exp_rd[1]);
      if (force_both && c < 4) begin
         chk1("rr_p1_turn", p1_ack, (c % 2) == 0);
         chk1("rr_p2_turn", p2_ack, (c % 2) == 1);
      end
   endtask

   initial begin
      idle_op = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
      exp_rd[0] = 16'h0000;
      exp_rd[1] = 16'h0000;
      prio      = 0;
      pend[0]   = 1'b0;
      pend[1]   = 1'b0;
      set_port(0, 1'b0, idle_op);
      set_port(1, 1'b0, idle_op);

      // Reset for two cycles
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk1("rst_p1_ack", p1_ack, 1'b0);
      chk1("rst_p2_ack", p2_ack, 1'b0);
      chk16("rst_p1_rdata", p1_rdata, 16'h0000);
      chk16("rst_p2_rdata", p2_rdata, 16'h0000);
      rst_n = 1'b1;

      single(0, 1'b0, 8'h10, 2'b11, 16'h0000);
      chk16("init_zero_read", p1_rdata, 16'h0000);

      single(0, 1'b1, 8'h10, 2'b11, 16'hBEEF);
      chk16("wr_keeps_rdata", p1_rdata, 16'h0000);
      single(1, 1'b0, 8'h10, 2'b00, 16'h0000);
      chk16("p2_reads_beef", p2_rdata, 16'hBEEF);

      // Byte address wraps at the top of the array
      single(1, 1'b1, 8'hFF, 2'b11, 16'h1234);
      single(0, 1'b0, 8'h00, 2'b00, 16'h0000);
      chk16("wrap_low_byte", {8'h00, p1_rdata[7:0]}, 16'h0012);
      single(0, 1'b0, 8'hFF, 2'b00, 16'h0000);
      chk16("wrap_word", p1_rdata, 16'h1234);

      single(0, 1'b1, 8'h20, 2'b11, 16'hBEEF);
      single(0, 1'b1, 8'h20, 2'b01, 16'h0011);
      single(0, 1'b1, 8'h20, 2'b00, 16'hFFFF);
      single(1, 1'b0, 8'h20, 2'b01, 16'h0000);
      chk16("be_merge", p2_rdata, 16'hBE11);

      // Write presented on the same edge as reset is discarded
      single(1, 1'b1, 8'h30, 2'b11, 16'hAAAA);
      set_port(1, 1'b1, '{we: 1'b1, addr: 8'h30, be: 2'b11, wdata: 16'h5555});
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk1("rst_wr_p2_ack", p2_ack, 1'b0);
      chk1("rst_wr_p1_ack", p1_ack, 1'b0);
      chk16("rst_wr_p1_rdata", p1_rdata, 16'h0000);
      chk16("rst_wr_p2_rdata", p2_rdata, 16'h0000);
      exp_rd[0] = 16'h0000;
      exp_rd[1] = 16'h0000;
      prio      = 0;
      set_port(1, 1'b0, idle_op);
      rst_n = 1'b1;
      single(0, 1'b0, 8'h30, 2'b00, 16'h0000);
      chk16("rst_wr_dropped", p1_rdata, 16'hAAAA);

      // Fresh reset, then sustained contention followed by random traffic
      rst_n = 1'b0;
      @(posedge clk); #1;
      exp_rd[0] = 16'h0000;
      exp_rd[1] = 16'h0000;
      prio      = 0;
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) traffic_cycle(1'b1, c);
      for (int c = 0; c < 300; c++) traffic_cycle(1'b0, c);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
